// File: rtl/cdc_vector_event_queue.sv
// Stability filter for a CDC-delivered vector. Each settled change is queued as an event
// holding the new value plus rise/fall masks, and the consumer takes events over valid/ready.
module cdc_vector_event_queue #(
    parameter int DATA_WIDTH    = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        cur_value,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [DATA_WIDTH-1:0]        evt_data,
    output logic [DATA_WIDTH-1:0]        evt_rise,
    output logic [DATA_WIDTH-1:0]        evt_fall,
    output logic [$clog2(DEPTH+1)-1:0]   evt_count,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [DATA_WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rise_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] fall_mem_q [DEPTH];

    logic commit, full, empty, push, pop;

    assign commit = (data_in == cand_q) && (cnt_q == CNT_MAX) && (cand_q != cur_q);
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign pop    = !empty && evt_ready;
    // A pop in the same cycle frees the slot, so a commit into a full FIFO still lands.
    assign push   = commit && (!full || pop);

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (data_in != cand_q) begin
            cand_d = data_in;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (commit) cur_d = cand_q;
        if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (commit && full && !pop) ovf_d = 1'b1;
        else if (clear_overflow)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                rise_mem_q[i] <= '0;
                fall_mem_q[i] <= '0;
            end
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) begin
                data_mem_q[wr_ptr_q] <= cand_q;
                rise_mem_q[wr_ptr_q] <= cand_q & ~cur_q;
                fall_mem_q[wr_ptr_q] <= ~cand_q & cur_q;
            end
        end
    end

    assign cur_value = cur_q;
    assign evt_valid = !empty;
    assign evt_data  = data_mem_q[rd_ptr_q];
    assign evt_rise  = rise_mem_q[rd_ptr_q];
    assign evt_fall  = fall_mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cdc_vector_event_queue.sv
// Directed bench for cdc_vector_event_queue: stimulus queues hand-computed events,
// and a negedge monitor checks every handshaked head entry against them.
module tb_cdc_vector_event_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [7:0] cur_value;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_data, evt_rise, evt_fall;
    logic [2:0] evt_count;
    logic       overflow;
    logic       clear_overflow;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb [$];

    cdc_vector_event_queue #(.DATA_WIDTH(8), .STABLE_CYCLES(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .cur_value(cur_value),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .evt_rise(evt_rise), .evt_fall(evt_fall), .evt_count(evt_count),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Value committed at the 5th edge after it is driven: first sample plus 4 stable samples.
    task automatic settle(input logic [7:0] v);
        data_in = v;
        repeat (5) step();
    endtask

    task automatic expect_evt(input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
        sb.push_back({d, r, f});
    endtask

    task automatic drain(input int n);
        evt_ready = 1'b1;
        repeat (n) step();
        evt_ready = 1'b0;
    endtask

    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!reset && evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0h expected none", evt_data);
                end else begin
                    e = sb.pop_front();
                    check("evt_data", {24'd0, evt_data}, {24'd0, e[23:16]});
                    check("evt_rise", {24'd0, evt_rise}, {24'd0, e[15:8]});
                    check("evt_fall", {24'd0, evt_fall}, {24'd0, e[7:0]});
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        data_in = 8'h00;
        evt_ready = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Idle after reset
        repeat (10) step();
        check("idle_valid", {31'd0, evt_valid}, 0);
        check("idle_count", {29'd0, evt_count}, 0);
        check("idle_cur", {24'd0, cur_value}, 0);
        check("idle_ovf", {31'd0, overflow}, 0);

        // First commit latency: valid exactly 4 edges after first 0x5A sample
        data_in = 8'h5A;
        expect_evt(8'h5A, 8'h5A, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            check("latency_not_yet", {31'd0, evt_valid}, 0);
        end
        step();
        check("latency_valid", {31'd0, evt_valid}, 1);
        check("latency_cur", {24'd0, cur_value}, 32'h5A);
        repeat (3) step();
        check("head_hold_valid", {31'd0, evt_valid}, 1);
        check("head_hold_data", {24'd0, evt_data}, 32'h5A);
        drain(1);
        check("popped_valid", {31'd0, evt_valid}, 0);
        check("popped_count", {29'd0, evt_count}, 0);

        // Glitch shorter than the filter, then a real change
        data_in = 8'h0F;
        repeat (3) step();
        data_in = 8'h5A;
        repeat (8) step();
        check("glitch_valid", {31'd0, evt_valid}, 0);
        check("glitch_cur", {24'd0, cur_value}, 32'h5A);
        expect_evt(8'h0F, 8'h05, 8'h50);
        settle(8'h0F);
        check("change_valid", {31'd0, evt_valid}, 1);
        check("change_cur", {24'd0, cur_value}, 32'h0F);
        drain(1);

        // Fill beyond depth; pointers wrap since two entries were used already
        expect_evt(8'h01, 8'h00, 8'h0E);
        settle(8'h01);
        expect_evt(8'h02, 8'h02, 8'h01);
        settle(8'h02);
        expect_evt(8'h04, 8'h04, 8'h02);
        settle(8'h04);
        expect_evt(8'h08, 8'h08, 8'h04);
        settle(8'h08);
        settle(8'h10);
        check("full_count", {29'd0, evt_count}, 4);
        check("full_ovf", {31'd0, overflow}, 1);
        check("full_cur", {24'd0, cur_value}, 32'h10);

        // Commit into full FIFO while popping the head
        data_in = 8'h20;
        expect_evt(8'h20, 8'h20, 8'h10);
        repeat (4) step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("pushpop_count", {29'd0, evt_count}, 4);
        check("pushpop_ovf", {31'd0, overflow}, 1);
        check("pushpop_cur", {24'd0, cur_value}, 32'h20);
        drain(4);
        check("drained_count", {29'd0, evt_count}, 0);
        check("drained_valid", {31'd0, evt_valid}, 0);

        // Clear overflow, refill, then clear on the same edge as a drop
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("clear_ovf", {31'd0, overflow}, 0);
        expect_evt(8'h01, 8'h01, 8'h20);
        settle(8'h01);
        expect_evt(8'h02, 8'h02, 8'h01);
        settle(8'h02);
        expect_evt(8'h04, 8'h04, 8'h02);
        settle(8'h04);
        expect_evt(8'h08, 8'h08, 8'h04);
        settle(8'h08);
        check("refill_ovf", {31'd0, overflow}, 0);
        data_in = 8'h40;
        repeat (4) step();
        clear_overflow = 1'b1;
        step();
        check("set_wins_ovf", {31'd0, overflow}, 1);
        check("set_wins_count", {29'd0, evt_count}, 4);
        check("set_wins_cur", {24'd0, cur_value}, 32'h40);
        step();
        clear_overflow = 1'b0;
        check("late_clear_ovf", {31'd0, overflow}, 0);

        // Async reset with two events queued
        drain(2);
        check("pre_reset_count", {29'd0, evt_count}, 2);
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid", {31'd0, evt_valid}, 0);
        check("rst_count", {29'd0, evt_count}, 0);
        check("rst_cur", {24'd0, cur_value}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        sb.delete();
        data_in = 8'h33;
        reset = 1'b0;
        expect_evt(8'h33, 8'h33, 8'h00);
        repeat (5) step();
        check("post_rst_valid", {31'd0, evt_valid}, 1);
        check("post_rst_cur", {24'd0, cur_value}, 32'h33);
        drain(1);
        step();
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
